// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
//   Serial pattern transmitter. It sends a PAT_W-bit pattern MSB-first on y and
//   repeats it reps times. An optional idle gap of gap_len ticks separates the
//   repetitions. Bits advance only on clocks where tick=1. It produces the same
//   single-bit serial stream that the sequence detectors consume.
//
//   Optional feature: when the macro SEQ_GEN_PARITY_EN is defined, each
//   repetition ends with one extra even-parity bit (^pattern). The default
//   build, with the macro undefined, contains no parity logic.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      transmission request, sampled only in IDLE
//   pat_in   in   PAT_W  pattern, latched when start is accepted
//   reps     in   CNT_W  repetition count, latched when start is accepted
//   gap_len  in   CNT_W  idle ticks between repetitions, latched when start is accepted
//   tick     in   1      bit-advance strobe
//   y        out  1      serial data (registered)
//   valid    out  1      y carries a pattern/parity bit (registered)
//   busy     out  1      transmission in progress (registered)
//   done     out  1      one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module seq_pattern_gen #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap_len,
    input  logic             tick,
    output logic             y,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic [CNT_W-1:0] r_gap_len;
    logic [CNT_W-1:0] r_rep;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_y;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    // w_sym is the symbol sent on the next SHIFT tick; w_last marks the final
    // symbol of a repetition.
    logic             w_sym;
    logic             w_last;

`ifdef SEQ_GEN_PARITY_EN
    // The parity phase follows data bit 0 within each repetition.
    logic             r_par_ph;

    always_comb begin
        w_sym  = r_par_ph ? ^r_pat : r_pat[r_idx];
        w_last = r_par_ph;
    end
`else
    always_comb begin
        w_sym  = r_pat[r_idx];
        w_last = (r_idx == '0);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_gap_len <= '0;
            r_rep     <= '0;
            r_gap_cnt <= '0;
            r_idx     <= '0;
            r_y       <= IDLE_BIT;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            r_par_ph  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pat     <= pat_in;
                        r_gap_len <= gap_len;
                        r_rep     <= reps;
                        r_idx     <= IDX_TOP;
                        r_busy    <= 1'b1;
`ifdef SEQ_GEN_PARITY_EN
                        r_par_ph  <= 1'b0;
`endif
                        r_state   <= (reps == '0) ? S_FIN : S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (tick) begin
                        r_y     <= w_sym;
                        r_valid <= 1'b1;
                        if (w_last) begin
                            // Repetition complete: rewind index, then decide
                            // between finishing, a gap, or a back-to-back rep.
                            r_idx <= IDX_TOP;
`ifdef SEQ_GEN_PARITY_EN
                            r_par_ph <= 1'b0;
`endif
                            r_rep <= r_rep - CNT_W'(1);
                            if (r_rep == CNT_W'(1)) begin
                                r_state <= S_FIN;
                            end else if (r_gap_len != '0) begin
                                r_gap_cnt <= r_gap_len;
                                r_state   <= S_GAP;
                            end
                        end else if (r_idx != '0) begin
                            r_idx <= r_idx - IDX_W'(1);
                        end
`ifdef SEQ_GEN_PARITY_EN
                        else begin
                            r_par_ph <= 1'b1;
                        end
`endif
                    end
                end

                S_GAP: begin
                    // Idle symbols also advance only on tick, so a slow tick
                    // stretches the gap just like it stretches data bits.
                    if (tick) begin
                        r_y       <= IDLE_BIT;
                        r_valid   <= 1'b0;
                        r_gap_cnt <= r_gap_cnt - CNT_W'(1);
                        if (r_gap_cnt == CNT_W'(1)) begin
                            r_state <= S_SHIFT;
                        end
                    end
                end

                S_FIN: begin
                    // Completion does not wait for tick.
                    r_y     <= IDLE_BIT;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign y     = r_y;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
